// File: rtl/pseudo_softmax_pkg.sv
// -----------------------------------------------------------------------------
// pseudo_softmax_pkg
// Shared types and constants for the pseudo-softmax back end.
//   state_t    : normalizer FSM states
//   DW_DEF     : default element / result width
//   RW_DEF     : default reciprocal width (Q0.RW)
//   SCALE_SH   : right shift taking e*recip (Q0.RW) down to Q0.DW
//   ROUND_C    : half-LSB added before that shift (round half-up)
//   scale_sat  : round, shift and saturate a product to dw bits
// -----------------------------------------------------------------------------
package pseudo_softmax_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        REQ  = 2'd1,
        EMIT = 2'd2,
        ZERO = 2'd3
    } state_t;

    localparam int DW_DEF   = 8;
    localparam int RW_DEF   = 16;
    localparam int SCALE_SH = RW_DEF - DW_DEF;
    localparam logic [63:0] ROUND_C = 64'd1 << (SCALE_SH - 1);

    // Round half-up at bit position sh, then clamp to the largest dw-bit
    // value. Works on a 64-bit container so any DW+RW up to 64 fits.
    function automatic logic [63:0] scale_sat(input logic [63:0] p,
                                              input int          sh,
                                              input int          dw);
        logic [63:0] rnd;
        logic [63:0] lim;
        rnd = (p + (64'd1 << (sh - 1))) >> sh;
        lim = (64'd1 << dw) - 64'd1;
        return (rnd > lim) ? lim : rnd;
    endfunction

endpackage

// File: rtl/softmax_scale_mul.sv
// -----------------------------------------------------------------------------
// softmax_scale_mul
// Registered multiply / round / saturate: o_data <= sat(round(e * recip)).
//   clk, rst_n : clock, async active-low reset
//   i_en       : load a new result this cycle; otherwise o_data holds
//   i_elem     : buffered exponent value e_k (DW bits)
//   i_recip    : latched reciprocal of the vector sum (Q0.RW)
//   o_data     : normalized probability, Q0.DW
// -----------------------------------------------------------------------------
module softmax_scale_mul
    import pseudo_softmax_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic [DW-1:0] i_elem,
    input  logic [RW-1:0] i_recip,
    output logic [DW-1:0] o_data
);

    localparam int PW = DW + RW;

    logic [PW-1:0] w_prod;
    logic [DW-1:0] r_data;

    assign w_prod = PW'(i_elem) * PW'(i_recip);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= DW'(scale_sat(64'(w_prod), RW - DW, DW));
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/softmax_normalizer.sv
// -----------------------------------------------------------------------------
// softmax_normalizer
// Buffers N exponent values, sums them, asks the reciprocal unit for
// 1/sum and streams out e_k * recip as Q0.DW probabilities.
//   clk, rst_n            : clock, async active-low reset
//   in_data/valid/ready   : exponent input stream (accepted in LOAD only)
//   sum_out/sum_valid     : vector sum, held while waiting for the reciprocal
//   recip_in/recip_valid  : reciprocal reply, sampled only in REQ
//   out_data/valid/ready  : probability output stream
//   busy                  : high whenever not in LOAD
//
// state | meaning
// LOAD  | accepting inputs, accumulating sum
// REQ   | sum_valid high, waiting for recip_valid
// EMIT  | streaming buf[k] * recip
// ZERO  | sum was zero: stream N zeros, no reciprocal request
// -----------------------------------------------------------------------------
module softmax_normalizer
    import pseudo_softmax_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF,
    parameter int SW = DW + $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [SW-1:0] sum_out,
    output logic          sum_valid,
    input  logic [RW-1:0] recip_in,
    input  logic          recip_valid,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);

    localparam int CW = $clog2(N);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_sum;
    logic [DW-1:0] r_buf [N];
    logic [RW-1:0] r_recip;
    logic          r_in_ready;
    logic          r_sum_valid;
    logic          r_out_valid;
    logic          r_busy;

    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_last;
    logic          w_emitting;
    logic          w_mul_en;
    logic [CW-1:0] w_ld_idx;
    logic [SW-1:0] w_sum_nxt;

    assign w_in_fire  = in_valid && r_in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_last     = (r_cnt == CW'(N - 1));
    assign w_emitting = (r_state == EMIT) || (r_state == ZERO);
    assign w_sum_nxt  = r_sum + SW'(in_data);

    // r_cnt counts completed output handshakes in EMIT/ZERO, so the element
    // to load next is r_cnt+1 on a handshake, or element 0 on the very first
    // load. Nothing is loaded on the final handshake, and nothing while the
    // current result is stalled.
    assign w_mul_en = w_emitting && (!r_out_valid || (out_ready && !w_last));
    assign w_ld_idx = r_out_valid ? (r_cnt + CW'(1)) : '0;

    softmax_scale_mul #(
        .DW (DW),
        .RW (RW)
    ) u_scale_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_mul_en),
        .i_elem  (r_buf[w_ld_idx]),
        .i_recip (r_recip),
        .o_data  (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= LOAD;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_recip     <= '0;
            r_in_ready  <= 1'b1;
            r_sum_valid <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_in_fire) begin
                        r_buf[r_cnt] <= in_data;
                        r_sum        <= w_sum_nxt;
                        r_cnt        <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                            if (w_sum_nxt != '0) begin
                                r_state     <= REQ;
                                r_sum_valid <= 1'b1;
                            end else begin
                                // Zero recip makes the multiplier emit zeros.
                                r_state <= ZERO;
                                r_recip <= '0;
                            end
                        end
                    end
                end
                REQ: begin
                    if (recip_valid) begin
                        r_recip     <= recip_in;
                        r_sum_valid <= 1'b0;
                        r_state     <= EMIT;
                    end
                end
                EMIT, ZERO: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (w_out_fire) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_out_valid <= 1'b0;
                            r_sum       <= '0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign sum_out   = r_sum;
    assign sum_valid = r_sum_valid;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule
